// File: rtl/adc128s_pkg.sv
// Shared constants for the ADC128S serial ADC behavioural model:
// frame geometry, address field location and conversion width.
package adc128s_pkg;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int ADDR_HI   = 13;
  localparam int ADDR_LO   = 11;
  localparam int DATA_W    = 12;
  localparam int PAD_W     = FRAME_LEN - DATA_W;

  localparam logic [CNT_W-1:0]  LAST_EDGE  = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_W-1:0] CH_DEFAULT = 12'h800;

  typedef logic [ADDR_HI-ADDR_LO:0] ch_addr_t;
endpackage

// File: rtl/adc128s_sync_edge_det.sv
// Two-flop synchronizer with a third history flop producing single-clk
// rise/fall pulses from the synchronized level.
module sync_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
endmodule

// File: rtl/adc128s_model.sv
// Behavioural ADC128S SPI slave: returns a fixed 12-bit value per channel,
// with the channel chosen by the control word of the previous frame.
module adc128s_model
  import adc128s_pkg::*;
#(
  parameter logic [DATA_W-1:0] CH0_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH1_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH2_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH3_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH4_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH5_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH6_VAL = CH_DEFAULT,
  parameter logic [DATA_W-1:0] CH7_VAL = CH_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO
);
  logic ss_s, ss_rise, ss_fall;
  logic sclk_s, sclk_rise, sclk_fall;

  sync_edge_det #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n),
    .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge_det #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK),
    .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  logic mosi_s1_q, mosi_s2_q;
  logic mosi_s1_d, mosi_s2_d;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [FRAME_LEN-1:0] in_sr_q, in_sr_d;
  logic [FRAME_LEN-1:0] out_sr_q, out_sr_d;
  ch_addr_t             addr_q, addr_d;

  logic [FRAME_LEN-1:0] sr_next;
  logic [DATA_W-1:0]    ch_val;

  always_comb begin
    ch_val = CH0_VAL;
    case (addr_q)
      3'd0: ch_val = CH0_VAL;
      3'd1: ch_val = CH1_VAL;
      3'd2: ch_val = CH2_VAL;
      3'd3: ch_val = CH3_VAL;
      3'd4: ch_val = CH4_VAL;
      3'd5: ch_val = CH5_VAL;
      3'd6: ch_val = CH6_VAL;
      3'd7: ch_val = CH7_VAL;
      default: ch_val = CH0_VAL;
    endcase
  end

  always_comb begin
    mosi_s1_d = MOSI;
    mosi_s2_d = mosi_s1_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    in_sr_d   = in_sr_q;
    out_sr_d  = out_sr_q;
    addr_d    = addr_q;
    sr_next   = {in_sr_q[FRAME_LEN-2:0], mosi_s2_q};

    // Frame start wins over any SCLK edge seen in the same cycle.
    if (ss_fall) begin
      cnt_d    = '0;
      done_d   = 1'b0;
      in_sr_d  = '0;
      out_sr_d = {{PAD_W{1'b0}}, ch_val};
    end else if (ss_rise) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (!ss_s) begin
      if (sclk_rise && !done_q) begin
        in_sr_d = sr_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_EDGE) begin
          done_d = 1'b1;
          addr_d = sr_next[ADDR_HI:ADDR_LO];
        end
      end
      if (sclk_fall)
        out_sr_d = done_q ? '0 : {out_sr_q[FRAME_LEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      in_sr_q   <= '0;
      out_sr_q  <= '0;
      addr_q    <= '0;
    end else begin
      mosi_s1_q <= mosi_s1_d;
      mosi_s2_q <= mosi_s2_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      in_sr_q   <= in_sr_d;
      out_sr_q  <= out_sr_d;
      addr_q    <= addr_d;
    end
  end

  // Only the address field of the control word matters.
  logic unused_bits;
  assign unused_bits = ^{sclk_s, in_sr_q[FRAME_LEN-1],
                         sr_next[FRAME_LEN-1:ADDR_HI+1], sr_next[ADDR_LO-1:0]};

  assign MISO = (!rst_n || ss_s) ? 1'bz : out_sr_q[FRAME_LEN-1];
endmodule

// File: tb/tb_adc128s_model.sv
// Directed bench for adc128s_model: two instances share the SPI bus inputs,
// one with default values (CH3=FFF), one with distinct per-channel values.
module tb_adc128s_model;
  logic clk = 1'b0;
  logic rst_n, ss_n, sclk, mosi;
  wire  miso_a, miso_b;
  pullup (miso_a);
  pullup (miso_b);

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  adc128s_model #(.CH3_VAL(12'hFFF)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso_a)
  );

  adc128s_model #(
    .CH0_VAL(12'h000), .CH1_VAL(12'h101), .CH2_VAL(12'h202), .CH3_VAL(12'h303),
    .CH4_VAL(12'h404), .CH5_VAL(12'h505), .CH6_VAL(12'h606), .CH7_VAL(12'h707)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso_b)
  );

  logic [31:0] ra, rb;

  // SCLK idles low; master samples MISO just before each rising edge.
  task automatic sclk_edge(input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    ra = {ra[30:0], miso_a};
    rb = {rb[30:0], miso_b};
    sclk = 1'b1;
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] w, input int nedges);
    ra = '0;
    rb = '0;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nedges; i++)
      sclk_edge((i < 16) ? w[15-i] : 1'b1);
    ss_n = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (miso_a !== 1'b1) $display("FAIL reset_hiz_a: got %b want released(1)", miso_a);
    else pass_cnt++;
    chk_cnt++;
    if (miso_b !== 1'b1) $display("FAIL reset_hiz_b: got %b want released(1)", miso_b);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (miso_a !== 1'b1) $display("FAIL idle_hiz_a: got %b want released(1)", miso_a);
    else pass_cnt++;
    chk_cnt++;
    if (miso_b !== 1'b1) $display("FAIL idle_hiz_b: got %b want released(1)", miso_b);
    else pass_cnt++;
  endtask

  task automatic test_first_frame;
    run_frame(16'h1800, 16);
    chk_cnt++;
    if (ra[15:0] !== 16'h0800) $display("FAIL first_frame_a: got %h want 0800", ra[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (rb[15:0] !== 16'h0000) $display("FAIL first_frame_b: got %h want 0000", rb[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_second_frame;
    run_frame(16'h0000, 16);
    chk_cnt++;
    if (ra[15:0] !== 16'h0FFF) $display("FAIL ch3_full_a: got %h want 0fff", ra[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (rb[15:0] !== 16'h0303) $display("FAIL ch3_b: got %h want 0303", rb[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_abort;
    run_frame(16'h2800, 8);
    chk_cnt++;
    if (miso_b !== 1'b1) $display("FAIL abort_hiz_b: got %b want released(1)", miso_b);
    else pass_cnt++;
    run_frame(16'h0000, 16);
    chk_cnt++;
    if (rb[15:0] !== 16'h0000) $display("FAIL abort_keep_addr_b: got %h want 0000", rb[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (ra[15:0] !== 16'h0800) $display("FAIL abort_keep_addr_a: got %h want 0800", ra[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_sweep;
    logic [15:0] exp_tab [8];
    logic [2:0]  a;
    exp_tab = '{16'h0000, 16'h0101, 16'h0202, 16'h0303,
                16'h0404, 16'h0505, 16'h0606, 16'h0707};
    for (int n = 0; n <= 8; n++) begin
      a = 3'(n);
      run_frame({2'b00, a, 11'b0}, 16);
      if (n > 0) begin
        chk_cnt++;
        if (rb[15:0] !== exp_tab[n-1])
          $display("FAIL sweep_ch%0d: got %h want %h", n - 1, rb[15:0], exp_tab[n-1]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_long_frame;
    run_frame(16'h3800, 16);
    run_frame(16'h3000, 20);
    chk_cnt++;
    if (rb[19:4] !== 16'h0707) $display("FAIL long_data_b: got %h want 0707", rb[19:4]);
    else pass_cnt++;
    chk_cnt++;
    if (rb[3:0] !== 4'h0) $display("FAIL long_extra_b: got %h want 0", rb[3:0]);
    else pass_cnt++;
    chk_cnt++;
    if (ra[19:0] !== 20'h08000) $display("FAIL long_all_a: got %h want 08000", ra[19:0]);
    else pass_cnt++;
    run_frame(16'h2800, 16);
    chk_cnt++;
    if (rb[15:0] !== 16'h0606) $display("FAIL long_addr16_b: got %h want 0606", rb[15:0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    w = 16'h1000;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 6; i++) sclk_edge(w[15-i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (miso_a !== 1'b1) $display("FAIL midrst_hiz_a: got %b want released(1)", miso_a);
    else pass_cnt++;
    chk_cnt++;
    if (miso_b !== 1'b1) $display("FAIL midrst_hiz_b: got %b want released(1)", miso_b);
    else pass_cnt++;
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(16'h0000, 16);
    chk_cnt++;
    if (rb[15:0] !== 16'h0000) $display("FAIL midrst_ch0_b: got %h want 0000", rb[15:0]);
    else pass_cnt++;
    chk_cnt++;
    if (ra[15:0] !== 16'h0800) $display("FAIL midrst_ch0_a: got %h want 0800", ra[15:0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_second_frame();
    test_abort();
    test_sweep();
    test_long_frame();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/adc128s_model.md
ADC128S_MODEL -- requirements
Module: adc128s_model

Interface
REQ-001 SHALL have parameter CH0_VAL..CH7_VAL, default 12'h800 each; 12-bit conversion result returned for channel 0..7.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain for all logic.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port SS_n  input  1  SPI slave select, active-low, frames one transaction.
REQ-005 SHALL have port SCLK  input  1  SPI serial clock from master, idle high or low, frequency ≤ clk/8.
REQ-006 SHALL have port MOSI  input  1  SPI data from master, control word MSB first.
REQ-007 SHALL have port MISO  output  1  SPI data to master, conversion word MSB first; high-Z while SS_n high.

Function
REQ-008 SHALL synchronize SCLK, SS_n and MOSI with two clk flops each, then detect SCLK rise/fall and SS_n fall/rise from synchronized values.
REQ-009 SHALL treat one frame as exactly 16 SCLK rising edges while SS_n low; 4-bit edge counter cleared on SS_n fall.
REQ-010 SHALL sample MOSI on each detected SCLK rise into a 16-bit shift register, MSB first.
REQ-011 SHALL take the next channel address from control bits [13:11] (3rd-5th bits received); other bits ignored.
REQ-012 SHALL update the stored channel address only on the 16th rising edge of a complete frame.
REQ-013 SHALL, on SS_n fall, load a 16-bit output shift register with {4'b0000, CHn_VAL} where n is the stored address (pipelined: data returned belongs to address sent in previous frame).
REQ-014 SHALL drive MISO from output register MSB, valid from SS_n fall (after synchronizer latency) and shifted left by one on each detected SCLK fall, zero filled.
REQ-015 SHALL ignore SCLK edges while SS_n high and ignore SCLK edges beyond the 16th in a frame (MISO held 0).
REQ-016 SHALL abort a frame if SS_n rises before the 16th rising edge: address unchanged, counter cleared.
REQ-017 SHALL tolerate back-to-back frames with SS_n high for ≥ 2 clk cycles between them.
REQ-018 SHALL, when SS_n fall and SCLK edge detected in the same clk cycle, give SS_n fall priority (load/clear first, edge discarded).

Reset
REQ-019 SHALL, while rst_n low, clear synchronizers to SS_n=1/SCLK=1/MOSI=0, edge counter to 0, both shift registers to 0, stored address to 0.
REQ-020 SHALL tri-state MISO during reset; first frame after reset returns CH0_VAL.
REQ-021 SHALL abort any in-progress frame on reset assertion; no state survives.

Structure
REQ-022 SHALL place frame length (16), address field position (13:11), data width (12) and default channel value in shared package adc128s_pkg.
REQ-023 SHALL use one sub-module, sync_edge_det (2-flop synchronizer plus rise/fall pulse outputs), instantiated for SCLK and SS_n.
REQ-024 SHALL keep all remaining logic (counters, shift registers, address register, value mux) in adc128s_model.

Verification
REQ-025 SHALL verify: reset, first frame sending channel 3 (MOSI word 16'h1800) -> MISO word 16'h0800 (CH0 default), stored address becomes 3.
REQ-026 SHALL verify: CH3_VAL=12'hFFF, second frame any control -> MISO word 16'h0FFF read MSB first on SCLK rise.
REQ-027 SHALL verify: frame aborted after 8 SCLK edges with address 5 -> next frame still returns previous channel value, address not 5.
REQ-028 SHALL verify: sweep addresses 0..7 with distinct CHn_VAL (12'h100*n+n) -> each following frame returns matching value with upper 4 bits 0.
REQ-029 SHALL verify: rst_n asserted mid-frame -> MISO high-Z, next frame returns CH0_VAL.
REQ-030 SHALL verify: 20 SCLK edges in one frame -> bits 17-20 read 0, address update occurs at edge 16 only.
